// File: rtl/swerv_types.sv
// Shared types for the DCCM single-error-correction writeback path.
package swerv_types;

  localparam int unsigned DCCM_DATA_WIDTH = 32;
  localparam int unsigned DCCM_ECC_WIDTH  = 7;
  localparam int unsigned DCCM_ADDR_WIDTH = 16;

  typedef struct packed {
    logic                       valid;
    logic [DCCM_ADDR_WIDTH-1:0] addr;
    logic [DCCM_DATA_WIDTH-1:0] data;
  } ecc_wb_entry_t;

  typedef enum logic [0:0] {IDLE, REQ} ecc_wb_state_e;

  function automatic logic [DCCM_ADDR_WIDTH-1:0] word_align(
    input logic [DCCM_ADDR_WIDTH-1:0] a
  );
    return {a[DCCM_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rvecc_encode.sv
// Hamming SEC-DED encoder: check bit i covers data at codeword positions with bit i set,
// top bit is overall parity over data and check bits.
module rvecc_encode #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ECC_WIDTH  = 7
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [ECC_WIDTH-1:0]  ecc_out
);

  localparam int unsigned MaxPos = DATA_WIDTH + ECC_WIDTH;

  logic [ECC_WIDTH-2:0] chk;

  always_comb begin
    int unsigned j;
    chk = '0;
    j   = 0;
    // Data occupies the non-power-of-two codeword positions starting at 3.
    for (int unsigned p = 3; p < MaxPos; p++) begin
      if (((p & (p - 1)) != 0) && (j < DATA_WIDTH)) begin
        for (int unsigned b = 0; b < ECC_WIDTH - 1; b++) begin
          if (p[b]) chk[b] = chk[b] ^ din[j];
        end
        j++;
      end
    end
  end

  assign ecc_out = {^{din, chk}, chk};

endmodule

// File: rtl/lsu_ecc_wb.sv
// DCCM single-error scrub queue: captures corrected DC3 words, holds them through DC4 for the
// kill decision, then writes them back with fresh ECC. Optional scrub counter: RV_DCCM_ECC_WB_CNT_EN.
module lsu_ecc_wb
  import swerv_types::*;
#(
  parameter int unsigned DATA_WIDTH = DCCM_DATA_WIDTH,
  parameter int unsigned ECC_WIDTH  = DCCM_ECC_WIDTH,
  parameter int unsigned ADDR_WIDTH = DCCM_ADDR_WIDTH,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  single_ecc_error_lo_dc3,
  input  logic                  single_ecc_error_hi_dc3,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_dc3,
  input  logic [ADDR_WIDTH-1:0] end_addr_dc3,
  input  logic [DATA_WIDTH-1:0] sec_data_lo_dc3,
  input  logic [DATA_WIDTH-1:0] sec_data_hi_dc3,
  input  logic                  lsu_kill_dc4,
  input  logic                  dec_tlu_core_ecc_disable,
  input  logic                  stbuf_wr_en,
  input  logic [ADDR_WIDTH-1:0] stbuf_wr_addr,
  output logic                  ecc_wb_req,
  input  logic                  ecc_wb_gnt,
  output logic [ADDR_WIDTH-1:0] ecc_wb_addr,
  output logic [DATA_WIDTH-1:0] ecc_wb_data,
  output logic [ECC_WIDTH-1:0]  ecc_wb_ecc,
  output logic                  ecc_wb_stall_dc3,
  output logic                  ecc_wb_overflow,
  output logic [CNT_WIDTH-1:0]  ecc_wb_count,
  input  logic                  ecc_wb_cnt_clr
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  ecc_wb_entry_t   dc4_lo_q, dc4_hi_q, cap_lo, cap_hi, head;
  ecc_wb_entry_t   q_q [DEPTH];
  ecc_wb_entry_t   q_d [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OccW-1:0] occ_q, occ_d;
  ecc_wb_state_e   state_q, state_d;
  logic            overflow_q, overflow_d;

  logic                  cap_en, head_hit, head_live, gnt_take, pop, enq_lo, enq_hi;
  logic [ADDR_WIDTH-1:0] stbuf_word;

  assign cap_en     = (single_ecc_error_lo_dc3 | single_ecc_error_hi_dc3) &
                      ~dec_tlu_core_ecc_disable;
  assign cap_lo     = '{valid: cap_en & single_ecc_error_lo_dc3,
                        addr:  word_align(lsu_addr_dc3),
                        data:  sec_data_lo_dc3};
  assign cap_hi     = '{valid: cap_en & single_ecc_error_hi_dc3,
                        addr:  word_align(end_addr_dc3),
                        data:  sec_data_hi_dc3};
  assign stbuf_word = word_align(stbuf_wr_addr);

  // A store-buffer drain to the same word makes the corrected copy stale.
  assign enq_lo = dc4_lo_q.valid & ~lsu_kill_dc4 &
                  ~(stbuf_wr_en & (dc4_lo_q.addr == stbuf_word));
  assign enq_hi = dc4_hi_q.valid & ~lsu_kill_dc4 &
                  ~(stbuf_wr_en & (dc4_hi_q.addr == stbuf_word));

  assign head      = q_q[rd_ptr_q];
  assign head_hit  = head.valid & stbuf_wr_en & (head.addr == stbuf_word);
  assign head_live = head.valid & ~head_hit;
  assign gnt_take  = (state_q == REQ) & head_live & ecc_wb_gnt;
  // Invalid heads drain silently; live heads leave only on grant.
  assign pop       = (occ_q != '0) & (~head_live | gnt_take);

  always_comb begin
    logic [PtrW-1:0] wr;
    int unsigned     n_free, n_acc;
    logic            drop;
    q_d = q_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (stbuf_wr_en && (q_q[i].addr == stbuf_word)) q_d[i].valid = 1'b0;
    end
    if (pop) q_d[rd_ptr_q].valid = 1'b0;

    n_free = DEPTH - 32'(occ_q) + 32'(pop);
    wr     = wr_ptr_q;
    n_acc  = 0;
    drop   = 1'b0;
    if (enq_lo) begin
      if (n_free > n_acc) begin
        q_d[wr] = dc4_lo_q;
        wr      = wr + PtrW'(1);
        n_acc++;
      end else begin
        drop = 1'b1;
      end
    end
    if (enq_hi) begin
      if (n_free > n_acc) begin
        q_d[wr] = dc4_hi_q;
        wr      = wr + PtrW'(1);
        n_acc++;
      end else begin
        drop = 1'b1;
      end
    end

    wr_ptr_d   = wr;
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    occ_d      = OccW'(32'(occ_q) + n_acc - 32'(pop));
    overflow_d = overflow_q | drop;

    if ((state_q == REQ) && head_hit) state_d = IDLE;
    else                              state_d = q_d[rd_ptr_d].valid ? REQ : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dc4_lo_q   <= '0;
      dc4_hi_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) q_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      dc4_lo_q   <= cap_lo;
      dc4_hi_q   <= cap_hi;
      q_q        <= q_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  assign ecc_wb_req       = (state_q == REQ) & head_live;
  assign ecc_wb_addr      = head.addr;
  assign ecc_wb_data      = head.data;
  assign ecc_wb_overflow  = overflow_q;
  assign ecc_wb_stall_dc3 = (32'(occ_q) + 32'(dc4_lo_q.valid) + 32'(dc4_hi_q.valid) + 2) > DEPTH;

  rvecc_encode #(
    .DATA_WIDTH(DATA_WIDTH),
    .ECC_WIDTH (ECC_WIDTH)
  ) u_rvecc_encode (
    .din    (head.data),
    .ecc_out(ecc_wb_ecc)
  );

`ifdef RV_DCCM_ECC_WB_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || ecc_wb_cnt_clr) cnt_q <= '0;
    else if (gnt_take && (cnt_q != '1)) cnt_q <= cnt_q + CNT_WIDTH'(1);
  end

  assign ecc_wb_count = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = ecc_wb_cnt_clr;
  assign ecc_wb_count   = '0;
`endif

endmodule

// File: tb/tb_lsu_ecc_wb.sv
// Directed bench for lsu_ecc_wb: capture, kill/disable, hazard, overflow, counter and reset.
module tb_lsu_ecc_wb;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned EW = 7;
  localparam int unsigned CW = 16;

`ifdef RV_DCCM_ECC_WB_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          sl, sh, kill, dis, st_en, gnt, cnt_clr;
  logic [AW-1:0] lsu_addr, end_addr, st_addr;
  logic [DW-1:0] sec_lo, sec_hi;
  logic          req, stall, ovf;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [EW-1:0] wb_ecc;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  lsu_ecc_wb #(
    .DATA_WIDTH(DW),
    .ECC_WIDTH (EW),
    .ADDR_WIDTH(AW),
    .DEPTH     (2),
    .CNT_WIDTH (CW)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .single_ecc_error_lo_dc3 (sl),
    .single_ecc_error_hi_dc3 (sh),
    .lsu_addr_dc3            (lsu_addr),
    .end_addr_dc3            (end_addr),
    .sec_data_lo_dc3         (sec_lo),
    .sec_data_hi_dc3         (sec_hi),
    .lsu_kill_dc4            (kill),
    .dec_tlu_core_ecc_disable(dis),
    .stbuf_wr_en             (st_en),
    .stbuf_wr_addr           (st_addr),
    .ecc_wb_req              (req),
    .ecc_wb_gnt              (gnt),
    .ecc_wb_addr             (wb_addr),
    .ecc_wb_data             (wb_data),
    .ecc_wb_ecc              (wb_ecc),
    .ecc_wb_stall_dc3        (stall),
    .ecc_wb_overflow         (ovf),
    .ecc_wb_count            (count),
    .ecc_wb_cnt_clr          (cnt_clr)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference SEC-DED check bits, written out per bit.
  function automatic logic [6:0] ref_ecc(input logic [31:0] d);
    logic [6:0] e;
    e[0] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[11]^d[13]^d[15]^d[17]^d[19]^d[21]^d[23]
           ^d[25]^d[26]^d[28]^d[30];
    e[1] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[10]^d[12]^d[13]^d[16]^d[17]^d[20]^d[21]^d[24]
           ^d[25]^d[27]^d[28]^d[31];
    e[2] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[10]^d[14]^d[15]^d[16]^d[17]^d[22]^d[23]^d[24]
           ^d[25]^d[29]^d[30]^d[31];
    e[3] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[10]^d[18]^d[19]^d[20]^d[21]^d[22]^d[23]^d[24]
           ^d[25];
    e[4] = d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[20]^d[21]^d[22]^d[23]
           ^d[24]^d[25];
    e[5] = d[26]^d[27]^d[28]^d[29]^d[30]^d[31];
    e[6] = (^d) ^ (^e[5:0]);
    return e;
  endfunction

  function automatic logic [CW-1:0] exp_cnt(input logic [CW-1:0] v);
    return CntEn ? v : '0;
  endfunction

  task automatic clr_dc3();
    sl = 1'b0; sh = 1'b0; lsu_addr = '0; end_addr = '0; sec_lo = '0; sec_hi = '0;
  endtask

  task automatic drive_lo(input logic [AW-1:0] a, input logic [DW-1:0] d);
    sl = 1'b1; lsu_addr = a; end_addr = a + 16'd3; sec_lo = d;
  endtask

  initial begin
    rst = 1'b1; kill = 1'b0; dis = 1'b0; st_en = 1'b0; st_addr = '0; gnt = 1'b0;
    cnt_clr = 1'b0;
    clr_dc3();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_req", req, 0);
    check_eq("rst_addr", wb_addr, 0);
    check_eq("rst_data", wb_data, 0);
    check_eq("rst_ecc", wb_ecc, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_count", count, 0);

    // Single lo error, no kill: request in DC5.
    @(negedge clk); drive_lo(16'h0104, 32'hDEADBEEF);
    @(negedge clk); clr_dc3(); #1;
    check_eq("t1_req_dc4", req, 0);
    check_eq("t1_stall_dc4", stall, 1);
    @(negedge clk); #1;
    check_eq("t1_req_dc5", req, 1);
    check_eq("t1_addr", wb_addr, 16'h0104);
    check_eq("t1_data", wb_data, 32'hDEADBEEF);
    check_eq("t1_ecc", wb_ecc, ref_ecc(32'hDEADBEEF));
    gnt = 1'b1;
    @(negedge clk); gnt = 1'b0; #1;
    check_eq("t1_req_after_gnt", req, 0);
    check_eq("t1_stall_after", stall, 0);

    // Dual access 0x0106..0x0109: two writes on consecutive granted cycles.
    @(negedge clk);
    sl = 1'b1; sh = 1'b1; lsu_addr = 16'h0106; end_addr = 16'h0109;
    sec_lo = 32'h11112222; sec_hi = 32'h33334444;
    @(negedge clk); clr_dc3();
    @(negedge clk); #1;
    check_eq("t2_req0", req, 1);
    check_eq("t2_addr0", wb_addr, 16'h0104);
    check_eq("t2_data0", wb_data, 32'h11112222);
    gnt = 1'b1;
    @(negedge clk); #1;
    check_eq("t2_req1", req, 1);
    check_eq("t2_addr1", wb_addr, 16'h0108);
    check_eq("t2_data1", wb_data, 32'h33334444);
    check_eq("t2_ecc1", wb_ecc, ref_ecc(32'h33334444));
    @(negedge clk); gnt = 1'b0; #1;
    check_eq("t2_req_done", req, 0);
    check_eq("t2_count", count, exp_cnt(16'd3));

    // Kill in DC4 discards the capture.
    @(negedge clk); drive_lo(16'h0140, 32'h01234567);
    @(negedge clk); clr_dc3(); kill = 1'b1;
    @(negedge clk); kill = 1'b0; #1;
    check_eq("t3_kill_req", req, 0);
    check_eq("t3_kill_stall", stall, 0);
    @(negedge clk); #1;
    check_eq("t3_kill_req2", req, 0);

    // ECC disable blocks capture.
    @(negedge clk); drive_lo(16'h0150, 32'h89ABCDEF); dis = 1'b1;
    @(negedge clk); clr_dc3(); dis = 1'b0; #1;
    check_eq("t3_dis_stall", stall, 0);
    @(negedge clk); #1;
    check_eq("t3_dis_req", req, 0);

    // Store-buffer drain to a queued word: req drops the same cycle, queue empties.
    @(negedge clk); drive_lo(16'h0200, 32'hCAFEF00D);
    @(negedge clk); clr_dc3();
    @(negedge clk); #1;
    check_eq("t4_req_before", req, 1);
    st_en = 1'b1; st_addr = 16'h0202; #1;
    check_eq("t4_req_drop", req, 0);
    @(negedge clk); st_en = 1'b0; st_addr = '0; #1;
    check_eq("t4_req_after", req, 0);
    check_eq("t4_empty", stall, 0);

    // Drain hitting the DC4 slot: never enqueued.
    @(negedge clk); drive_lo(16'h0300, 32'h0000FFFF);
    @(negedge clk); clr_dc3(); st_en = 1'b1; st_addr = 16'h0301;
    @(negedge clk); st_en = 1'b0; st_addr = '0; #1;
    check_eq("t4_dc4_req", req, 0);
    check_eq("t4_dc4_empty", stall, 0);

    // Fill DEPTH=2 with gnt low, then force a third capture.
    @(negedge clk);
    sl = 1'b1; sh = 1'b1; lsu_addr = 16'h0402; end_addr = 16'h0405;
    sec_lo = 32'hA5A5A5A5; sec_hi = 32'h5A5A5A5A;
    @(negedge clk); clr_dc3(); #1;
    check_eq("t5_stall_before", stall, 1);
    @(negedge clk); #1;
    check_eq("t5_req_a", req, 1);
    check_eq("t5_addr_a", wb_addr, 16'h0400);
    drive_lo(16'h0500, 32'h0F0F0F0F);
    @(negedge clk); clr_dc3(); #1;
    check_eq("t5_ovf_pre", ovf, 0);
    @(negedge clk); #1;
    check_eq("t5_ovf", ovf, 1);
    check_eq("t5_hold_addr_a", wb_addr, 16'h0400);
    check_eq("t5_hold_data_a", wb_data, 32'hA5A5A5A5);
    gnt = 1'b1;
    @(negedge clk); #1;
    check_eq("t5_addr_b", wb_addr, 16'h0404);
    check_eq("t5_data_b", wb_data, 32'h5A5A5A5A);
    check_eq("t5_req_b", req, 1);
    @(negedge clk); gnt = 1'b0; #1;
    check_eq("t5_req_done", req, 0);
    check_eq("t5_empty", stall, 0);
    check_eq("t5_ovf_sticky", ovf, 1);
    check_eq("t5_count", count, exp_cnt(16'd5));

    // Continuous stream with gnt held: one write per cycle until the counter saturates.
    @(negedge clk); drive_lo(16'h0800, 32'h12345678); gnt = 1'b1;
    repeat (65540) @(negedge clk);
    clr_dc3();
    repeat (4) @(negedge clk);
    gnt = 1'b0; #1;
    check_eq("t6_sat", count, exp_cnt(16'hFFFF));
    check_eq("t6_req_done", req, 0);
    check_eq("t6_empty", stall, 0);

    // Clear has priority over a simultaneous grant.
    @(negedge clk); drive_lo(16'h0900, 32'h0BADF00D);
    @(negedge clk); clr_dc3();
    @(negedge clk); #1;
    check_eq("t6_req", req, 1);
    gnt = 1'b1; cnt_clr = 1'b1;
    @(negedge clk); gnt = 1'b0; cnt_clr = 1'b0; #1;
    check_eq("t6_clr", count, 0);
    check_eq("t6_req_after_clr", req, 0);
    @(negedge clk); drive_lo(16'h0904, 32'h00C0FFEE);
    @(negedge clk); clr_dc3();
    @(negedge clk); gnt = 1'b1;
    @(negedge clk); gnt = 1'b0; #1;
    check_eq("t6_count1", count, exp_cnt(16'd1));

    // Reset mid-request drops req and discards everything.
    @(negedge clk); drive_lo(16'h0A00, 32'hFEEDFACE);
    @(negedge clk); clr_dc3();
    @(negedge clk); #1;
    check_eq("t7_req", req, 1);
    rst = 1'b1;
    @(negedge clk); #1;
    check_eq("t7_rst_req", req, 0);
    check_eq("t7_rst_addr", wb_addr, 0);
    check_eq("t7_rst_ovf", ovf, 0);
    check_eq("t7_rst_count", count, 0);
    rst = 1'b0;
    @(negedge clk); #1;
    check_eq("t7_post_req", req, 0);
    check_eq("t7_post_stall", stall, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
